// File: rtl/imm_encoder_if.sv
// Request/response bundle for the immediate encoder.
// master drives requests and consumes results; slave is the encoder.
interface imm_encoder_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] base_inst;
  logic [31:0] imm;
  logic [2:0]  mode;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_inst;
  logic        out_err;

  modport master (
    output in_valid, base_inst, imm, mode, out_ready,
    input  in_ready, out_valid, out_inst, out_err
  );

  modport slave (
    input  in_valid, base_inst, imm, mode, out_ready,
    output in_ready, out_valid, out_inst, out_err
  );
endinterface

// File: rtl/imm_encoder.sv
// Writes an immediate into an instruction word, queued in a small output FIFO.
// Define IMM_RANGE_CHECK_EN to flag immediates that do not fit their format.
module imm_encoder #(
  parameter int FIFO_DEPTH = 2,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rstn,
  imm_encoder_if.slave     bus,
  output logic [CNT_W-1:0] enc_cnt,
  output logic [CNT_W-1:0] err_cnt
);

  localparam int AW = $clog2(FIFO_DEPTH);

  logic [31:0]      w_inst;
  logic             w_rng;
  logic             w_err;
  logic             w_full;
  logic             w_empty;
  logic             w_push;
  logic             w_pop;
  logic [AW:0]      r_wp;
  logic [AW:0]      r_rp;
  logic             r_live;
  logic [32:0]      r_mem [FIFO_DEPTH];
  logic [CNT_W-1:0] r_enc;
  logic [CNT_W-1:0] r_errc;

  always_comb begin
    w_inst = bus.base_inst;
    case (bus.mode)
      3'd1: w_inst[31:20] = bus.imm[11:0];
      3'd2: w_inst[24:20] = bus.imm[4:0];
      3'd3: w_inst[31:12] = bus.imm[31:12];
      3'd4: w_inst[31:12] = {bus.imm[20], bus.imm[10:1],
                             bus.imm[11], bus.imm[19:12]};
      3'd5: begin
        w_inst[31:25] = {bus.imm[12], bus.imm[10:5]};
        w_inst[11:7]  = {bus.imm[4:1], bus.imm[11]};
      end
      3'd6: begin
        w_inst[31:25] = bus.imm[11:5];
        w_inst[11:7]  = bus.imm[4:0];
      end
      default: ;
    endcase
  end

`ifdef IMM_RANGE_CHECK_EN
  // An even value fits N signed bits when every bit above N-1 matches the sign.
  logic w_fit12;
  logic w_fit13;
  logic w_fit21;
  assign w_fit12 = (&bus.imm[31:11]) | ~(|bus.imm[31:11]);
  assign w_fit13 = (&bus.imm[31:12]) | ~(|bus.imm[31:12]);
  assign w_fit21 = (&bus.imm[31:20]) | ~(|bus.imm[31:20]);

  always_comb begin
    w_rng = 1'b0;
    case (bus.mode)
      3'd1, 3'd6: w_rng = ~w_fit12;
      3'd2:       w_rng = |bus.imm[31:5];
      3'd3:       w_rng = |bus.imm[11:0];
      3'd4:       w_rng = bus.imm[0] | ~w_fit21;
      3'd5:       w_rng = bus.imm[0] | ~w_fit13;
      default:    w_rng = 1'b0;
    endcase
  end
`else
  assign w_rng = 1'b0;
`endif

  assign w_err   = w_rng | (bus.mode == 3'd7);
  assign w_empty = (r_wp == r_rp);
  assign w_full  = (r_wp[AW] != r_rp[AW]) &&
                   (r_wp[AW-1:0] == r_rp[AW-1:0]);
  assign w_push  = bus.in_valid & bus.in_ready;
  assign w_pop   = ~w_empty & bus.out_ready;

  assign bus.in_ready  = r_live & ~w_full;
  assign bus.out_valid = ~w_empty;
  assign bus.out_inst  = w_empty ? 32'd0 : r_mem[r_rp[AW-1:0]][31:0];
  assign bus.out_err   = w_empty ? 1'b0  : r_mem[r_rp[AW-1:0]][32];
  assign enc_cnt       = r_enc;
  assign err_cnt       = r_errc;

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wp[AW-1:0]] <= {w_err, w_inst};
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_wp   <= '0;
      r_rp   <= '0;
      r_live <= 1'b0;
      r_enc  <= '0;
      r_errc <= '0;
    end else begin
      r_live <= 1'b1;
      if (w_push) r_wp <= r_wp + 1'b1;
      if (w_pop)  r_rp <= r_rp + 1'b1;
      if (w_push && r_enc != '1)
        r_enc <= r_enc + CNT_W'(1);
      if (w_push && w_err && r_errc != '1)
        r_errc <= r_errc + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_imm_encoder.sv
// Directed plus random bench for imm_encoder against a queue-based model.
// Expected error flags follow IMM_RANGE_CHECK_EN.
module tb_imm_encoder;

  localparam int D    = 2;
  localparam int CMAX = 65535;

  typedef struct {
    logic [31:0] inst;
    logic        err;
  } ent_t;

  logic        clk;
  logic        rstn;
  logic [15:0] enc_cnt;
  logic [15:0] err_cnt;

  imm_encoder_if bus ();

  imm_encoder #(.FIFO_DEPTH(D), .CNT_W(16)) dut (
    .clk     (clk),
    .rstn    (rstn),
    .bus     (bus),
    .enc_cnt (enc_cnt),
    .err_cnt (err_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   n_cmp;
  int   n_bad;
  int   n_enc;
  int   n_errs;
  bit   live;
  ent_t q [$];

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] put(logic [31:0] r, logic [31:0] v,
                                      int dhi, int dlo, int slo);
    for (int b = dlo; b <= dhi; b++) r[b] = v[slo + b - dlo];
    return r;
  endfunction

  function automatic ent_t model(logic [31:0] b, logic [31:0] v,
                                 logic [2:0] m);
    ent_t e;
    int   s;
    s = $signed(v);
    e.inst = b;
    e.err  = (m == 3'd7);
    case (m)
      3'd1: e.inst = put(b, v, 31, 20, 0);
      3'd2: e.inst = put(b, v, 24, 20, 0);
      3'd3: e.inst = put(b, v, 31, 12, 12);
      3'd4: begin
        e.inst = put(b, v, 31, 31, 20);
        e.inst = put(e.inst, v, 30, 21, 1);
        e.inst = put(e.inst, v, 20, 20, 11);
        e.inst = put(e.inst, v, 19, 12, 12);
      end
      3'd5: begin
        e.inst = put(b, v, 31, 31, 12);
        e.inst = put(e.inst, v, 30, 25, 5);
        e.inst = put(e.inst, v, 11, 8, 1);
        e.inst = put(e.inst, v, 7, 7, 11);
      end
      3'd6: begin
        e.inst = put(b, v, 31, 25, 5);
        e.inst = put(e.inst, v, 11, 7, 0);
      end
      default: ;
    endcase
`ifdef IMM_RANGE_CHECK_EN
    case (m)
      3'd1, 3'd6: e.err = (s < -2048) || (s > 2047);
      3'd2: e.err = (v > 32'd31);
      3'd3: e.err = (v % 4096) != 0;
      3'd4: e.err = v[0] || (s < -1048576) || (s > 1048574);
      3'd5: e.err = v[0] || (s < -4096) || (s > 4094);
      default: ;
    endcase
`else
    if (s == 0 && m == 3'd0) e.err = 1'b0;
`endif
    return e;
  endfunction

  task automatic check_all();
    chk("out_valid", bus.out_valid, q.size() != 0);
    chk("in_ready", bus.in_ready, live && q.size() < D);
    if (q.size() != 0) begin
      chk("out_inst", bus.out_inst, q[0].inst);
      chk("out_err", bus.out_err, q[0].err);
    end
    chk("enc_cnt", enc_cnt, n_enc);
    chk("err_cnt", err_cnt, n_errs);
  endtask

  task automatic tick();
    bit   push;
    bit   pop;
    ent_t e;
    pop  = rstn && q.size() != 0 && bus.out_ready;
    push = rstn && live && bus.in_valid && q.size() < D;
    e    = model(bus.base_inst, bus.imm, bus.mode);
    @(posedge clk);
    if (pop) void'(q.pop_front());
    if (push) begin
      q.push_back(e);
      if (n_enc < CMAX) n_enc++;
      if (e.err && n_errs < CMAX) n_errs++;
    end
    live = rstn;
    @(negedge clk);
    check_all();
  endtask

  task automatic setin(logic [31:0] b, logic [31:0] v, logic [2:0] m);
    bus.base_inst = b;
    bus.imm       = v;
    bus.mode      = m;
    bus.in_valid  = 1'b1;
  endtask

  task automatic req(logic [31:0] b, logic [31:0] v, logic [2:0] m);
    setin(b, v, m);
    tick();
    bus.in_valid = 1'b0;
  endtask

  logic ck;

  initial begin
    n_cmp = 0; n_bad = 0; n_enc = 0; n_errs = 0; live = 1'b0;
`ifdef IMM_RANGE_CHECK_EN
    ck = 1'b1;
`else
    ck = 1'b0;
`endif
    rstn = 1'b0;
    bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    bus.base_inst = '0; bus.imm = '0; bus.mode = '0;
    #2;
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_out_inst", bus.out_inst, 0);
    chk("rst_out_err", bus.out_err, 0);
    chk("rst_enc_cnt", enc_cnt, 0);
    chk("rst_err_cnt", err_cnt, 0);
    @(negedge clk);
    rstn = 1'b1;
    tick();
    chk("ready_after_rst", bus.in_ready, 1);

    req(32'h13, 32'hFFFFFFFF, 3'd1);
    chk("tp_I", bus.out_inst, 32'hFFF00013);
    chk("tp_I_err", bus.out_err, 0);
    chk("tp_I_cnt", enc_cnt, 1);
    tick();
    req(32'h63, 32'd8, 3'd5);
    chk("tp_B", bus.out_inst, 32'h00000463);
    tick();
    req(32'h6F, 32'hFFFFFFFC, 3'd4);
    chk("tp_J", bus.out_inst, 32'hFFDFF06F);
    tick();
    req(32'h2023, 32'hFFFFFFF8, 3'd6);
    chk("tp_S", bus.out_inst, 32'hFE002C23);
    tick();
    req(32'h37, 32'h12345000, 3'd3);
    chk("tp_U", bus.out_inst, 32'h12345037);
    tick();
    req(32'h63, 32'd3, 3'd5);
    chk("tp_B_odd", bus.out_inst, 32'h00000163);
    chk("tp_B_odd_err", bus.out_err, ck);
    chk("tp_B_odd_ecnt", err_cnt, ck);
    tick();
    req(32'h13, 32'd2048, 3'd1);
    chk("tp_I_2048", bus.out_inst, 32'h80000013);
    chk("tp_I_2048_err", bus.out_err, ck);
    tick();
    req(32'hDEADBEEF, 32'd5, 3'd7);
    chk("tp_m7", bus.out_inst, 32'hDEADBEEF);
    chk("tp_m7_err", bus.out_err, 1);
    tick();

    bus.out_ready = 1'b0;
    setin(32'h13, 32'd1, 3'd1);
    tick();
    setin(32'h13, 32'd2, 3'd1);
    tick();
    chk("full_ready", bus.in_ready, 0);
    setin(32'h13, 32'd3, 3'd1);
    tick();
    tick();
    chk("stall_head", bus.out_inst, 32'h00100013);
    bus.out_ready = 1'b1;
    tick();
    chk("pop1_head", bus.out_inst, 32'h00200013);
    tick();
    chk("pop2_head", bus.out_inst, 32'h00300013);
    bus.in_valid = 1'b0;
    tick();

    for (int i = 0; i < 300; i++) begin
      logic [31:0] v;
      case ($urandom % 3)
        0: v = $urandom;
        1: v = $urandom_range(0, 8191) - 32'd4096;
        default: v = $urandom_range(0, 4194303) - 32'd2097152;
      endcase
      bus.in_valid  = ($urandom % 4) != 0;
      bus.out_ready = ($urandom % 3) != 0;
      bus.base_inst = $urandom;
      bus.imm       = v;
      bus.mode      = 3'($urandom % 8);
      tick();
    end

    bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    repeat (3) tick();
    bus.out_ready = 1'b0;
    req(32'h13, 32'd7, 3'd1);
    req(32'h13, 32'd9, 3'd1);
    chk("pre_rst_full", bus.in_ready, 0);
    rstn = 1'b0;
    #1;
    q.delete(); n_enc = 0; n_errs = 0; live = 1'b0;
    chk("mid_rst_valid", bus.out_valid, 0);
    chk("mid_rst_inst", bus.out_inst, 0);
    chk("mid_rst_enc", enc_cnt, 0);
    chk("mid_rst_err", err_cnt, 0);
    tick();
    rstn = 1'b1;
    tick();
    bus.out_ready = 1'b1;
    req(32'h13, 32'd11, 3'd1);
    chk("post_rst_head", bus.out_inst, 32'h00B00013);
    chk("post_rst_cnt", enc_cnt, 1);
    tick();
    chk("post_rst_alone", bus.out_valid, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
